// File: rtl/integer_alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational integer ALU, with one registered
// response slot per requester. Define INTEGER_ALU_ARBITER_FIXED_PRIO_EN for fixed priority (req0 wins).

module integer_alu_arbiter_slot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  acc,
   input  logic                  rsp_ready,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_carry,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_carry
);
   // Acceptance wins over drain so a slot emptied this cycle is refilled without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
      end else if (acc) begin
         rsp_valid <= 1'b1;
         rsp_data  <= alu_out;
         rsp_carry <= alu_carry;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

module integer_alu_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [5:0]            req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [5:0]            req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   output logic                  rsp0_carry,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic                  rsp1_carry,
   output logic                  alu_e,
   output logic [5:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_carry
);
   localparam int NUM_REQ = 2;

   typedef struct packed {
      logic [5:0]            op;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } req_t;

   req_t [NUM_REQ-1:0]                  req;
   logic [NUM_REQ-1:0]                  req_vld;
   logic [NUM_REQ-1:0]                  rsp_rdy;
   logic [NUM_REQ-1:0]                  rsp_vld;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_dat;
   logic [NUM_REQ-1:0]                  rsp_cy;
   logic [NUM_REQ-1:0]                  elig;
   logic [NUM_REQ-1:0]                  grant;

   assign req[0]  = '{op: req0_op, a: req0_a, b: req0_b};
   assign req[1]  = '{op: req1_op, a: req1_a, b: req1_b};
   assign req_vld = {req1_valid, req0_valid};
   assign rsp_rdy = {rsp1_ready, rsp0_ready};
   assign elig    = req_vld & (~rsp_vld | rsp_rdy);

`ifdef INTEGER_ALU_ARBITER_FIXED_PRIO_EN
   localparam logic prio = 1'b0;
`else
   logic prio;

   // Point at the requester that lost (or sat out) the last accepted cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      prio <= 1'b0;
      else if (|grant) prio <= grant[0];
   end
`endif

   // rst_n gates the grant so nothing handshakes while the slots are held in reset.
   always_comb begin
      grant = '0;
      if (rst_n) begin
         if (&elig) grant[prio] = 1'b1;
         else       grant       = elig;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_comb begin
      alu_e  = 1'b0;
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            alu_e  = 1'b1;
            alu_op = req[i].op;
            alu_a  = req[i].a;
            alu_b  = req[i].b;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      integer_alu_arbiter_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .acc       (grant[g]),
         .rsp_ready (rsp_rdy[g]),
         .alu_out   (alu_out),
         .alu_carry (alu_carry),
         .rsp_valid (rsp_vld[g]),
         .rsp_data  (rsp_dat[g]),
         .rsp_carry (rsp_cy[g])
      );
   end

   assign rsp0_valid = rsp_vld[0];
   assign rsp0_data  = rsp_dat[0];
   assign rsp0_carry = rsp_cy[0];
   assign rsp1_valid = rsp_vld[1];
   assign rsp1_data  = rsp_dat[1];
   assign rsp1_carry = rsp_cy[1];
endmodule

// File: tb/tb_integer_alu_arbiter.sv
// Directed bench for integer_alu_arbiter with a behavioural ALU and per-requester result queues.
module tb_integer_alu_arbiter;
   // Stand-in opcode encodings; the arbiter passes opcodes through untouched.
   localparam logic [5:0] OP_PLUS = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_BAD  = 6'h3F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry;
   logic [5:0]  req_op [2];
   logic [31:0] req_a [2];
   logic [31:0] req_b [2];
   logic [31:0] rsp_data [2];
   logic        alu_e, alu_carry;
   logic [5:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_out;

   int errors = 0;
   int checks = 0;
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic exp0;

   always #5 clk = ~clk;

   function automatic logic [32:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_PLUS: return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         default: return '0;
      endcase
   endfunction

   assign {alu_carry, alu_out} = alu_e ? alu_model(alu_op, alu_a, alu_b) : 33'd0;

   integer_alu_arbiter #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
      .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
      .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]), .rsp0_carry(rsp_carry[0]),
      .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]), .rsp1_carry(rsp_carry[1]),
      .alu_e(alu_e), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_carry(alu_carry)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int n, input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid[n] = v;
      req_op[n]    = op;
      req_a[n]     = a;
      req_b[n]     = b;
   endtask

   // Called at the falling edge: compare each slot with its queue head, then pop consumed
   // results and push newly accepted ones, then move to just past the next rising edge.
   task automatic sb_step();
      if (q0.size() != 0) begin
         chk("rsp0_valid", 64'(rsp_valid[0]), 64'd1);
         chk("rsp0_result", 64'({rsp_carry[0], rsp_data[0]}), 64'(q0[0]));
      end else chk("rsp0_valid", 64'(rsp_valid[0]), 64'd0);
      if (q1.size() != 0) begin
         chk("rsp1_valid", 64'(rsp_valid[1]), 64'd1);
         chk("rsp1_result", 64'({rsp_carry[1], rsp_data[1]}), 64'(q1[0]));
      end else chk("rsp1_valid", 64'(rsp_valid[1]), 64'd0);
      if (rsp_valid[0] && rsp_ready[0] && q0.size() != 0) void'(q0.pop_front());
      if (rsp_valid[1] && rsp_ready[1] && q1.size() != 0) void'(q1.pop_front());
      if (req_valid[0] && req_ready[0]) q0.push_back(alu_model(req_op[0], req_a[0], req_b[0]));
      if (req_valid[1] && req_ready[1]) q1.push_back(alu_model(req_op[1], req_a[1], req_b[1]));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_alu();
      chk("idle_alu_e", 64'(alu_e), 64'd0);
      chk("idle_alu_op", 64'(alu_op), 64'd0);
      chk("idle_alu_a", 64'(alu_a), 64'd0);
      chk("idle_alu_b", 64'(alu_b), 64'd0);
   endtask

   initial begin
      // Reset with req0 pending: nothing may be granted.
      rst_n = 1'b0;
      rsp_ready = 2'b11;
      drv(0, 1'b1, OP_PLUS, 32'd5, 32'd7);
      drv(1, 1'b0, OP_PLUS, 32'd0, 32'd0);
      @(negedge clk);
      chk("rst_req0_ready", 64'(req_ready[0]), 64'd0);
      chk("rst_alu_e", 64'(alu_e), 64'd0);
      chk("rst_rsp0_data", 64'(rsp_data[0]), 64'd0);
      chk("rst_rsp0_carry", 64'(rsp_carry[0]), 64'd0);
      chk("rst_rsp1_carry", 64'(rsp_carry[1]), 64'd0);
      sb_step();

      // Single ops on requester 0.
      rst_n = 1'b1;
      @(negedge clk);
      chk("plus_ready0", 64'(req_ready[0]), 64'd1);
      chk("plus_alu_e", 64'(alu_e), 64'd1);
      chk("plus_alu_op", 64'(alu_op), 64'(OP_PLUS));
      chk("plus_alu_a", 64'(alu_a), 64'd5);
      chk("plus_alu_b", 64'(alu_b), 64'd7);
      sb_step();

      drv(0, 1'b1, OP_PLUS, 32'hFFFF_FFFF, 32'd1);
      @(negedge clk);
      chk("plus_data", 64'(rsp_data[0]), 64'd12);
      chk("plus_carry", 64'(rsp_carry[0]), 64'd0);
      sb_step();

      drv(0, 1'b1, OP_SUB, 32'd3, 32'd5);
      @(negedge clk);
      chk("wrap_data", 64'(rsp_data[0]), 64'd0);
      chk("wrap_carry", 64'(rsp_carry[0]), 64'd1);
      sb_step();

      // Unknown opcode from requester 1 alone.
      drv(0, 1'b0, OP_PLUS, 32'd0, 32'd0);
      drv(1, 1'b1, OP_BAD, 32'd9, 32'd9);
      @(negedge clk);
      chk("sub_data", 64'(rsp_data[0]), 64'hFFFF_FFFE);
      chk("sub_carry", 64'(rsp_carry[0]), 64'd1);
      chk("bad_ready1", 64'(req_ready[1]), 64'd1);
      chk("bad_ready0", 64'(req_ready[0]), 64'd0);
      chk("bad_alu_op", 64'(alu_op), 64'(OP_BAD));
      sb_step();

      // Requester 1 drains and refills in one cycle, then holds its result.
      drv(1, 1'b1, OP_PLUS, 32'd100, 32'd23);
      @(negedge clk);
      chk("refill_ready1", 64'(req_ready[1]), 64'd1);
      sb_step();

      drv(1, 1'b0, OP_PLUS, 32'd0, 32'd0);
      rsp_ready = 2'b01;
      @(negedge clk);
      chk_idle_alu();
      chk("hold_rsp1_data", 64'(rsp_data[1]), 64'd123);
      sb_step();

      // Asynchronous reset mid-cycle while rsp1 holds a result.
      drv(0, 1'b1, OP_PLUS, 32'd1, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rsp1_valid", 64'(rsp_valid[1]), 64'd0);
      chk("arst_rsp1_data", 64'(rsp_data[1]), 64'd0);
      chk("arst_rsp1_carry", 64'(rsp_carry[1]), 64'd0);
      chk("arst_ready0", 64'(req_ready[0]), 64'd0);
      chk("arst_alu_e", 64'(alu_e), 64'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      sb_step();

      // Contention with both response slots always ready.
      rst_n = 1'b1;
      rsp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         drv(0, 1'b1, OP_PLUS, 32'(k), 32'd1000);
         drv(1, 1'b1, OP_SUB, 32'd500, 32'(k));
`ifdef INTEGER_ALU_ARBITER_FIXED_PRIO_EN
         exp0 = 1'b1;
`else
         exp0 = (k % 2 == 0);
`endif
         @(negedge clk);
         chk($sformatf("cont%0d_ready0", k), 64'(req_ready[0]), 64'(exp0));
         chk($sformatf("cont%0d_ready1", k), 64'(req_ready[1]), 64'(!exp0));
         sb_step();
      end

      // Backpressure on slot 0 while requester 1 keeps flowing.
      drv(1, 1'b0, OP_PLUS, 32'd0, 32'd0);
      drv(0, 1'b1, OP_PLUS, 32'd40, 32'd2);
      @(negedge clk);
      chk("bp_fill_ready0", 64'(req_ready[0]), 64'd1);
      sb_step();

      rsp_ready = 2'b10;
      drv(0, 1'b1, OP_PLUS, 32'd50, 32'd5);
      drv(1, 1'b1, OP_PLUS, 32'd60, 32'd6);
      @(negedge clk);
      chk("bp_ready0", 64'(req_ready[0]), 64'd0);
      chk("bp_ready1", 64'(req_ready[1]), 64'd1);
      sb_step();

      rsp_ready = 2'b01;
      @(negedge clk);
      chk("bp_release_ready0", 64'(req_ready[0]), 64'd1);
      chk("bp_release_ready1", 64'(req_ready[1]), 64'd0);
      sb_step();

      // Idle with slots held; priority must not move.
      rsp_ready = 2'b00;
      drv(0, 1'b0, OP_PLUS, 32'd0, 32'd0);
      drv(1, 1'b0, OP_PLUS, 32'd0, 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk_idle_alu();
         chk("idle_rsp0_data", 64'(rsp_data[0]), 64'd55);
         sb_step();
      end

      rsp_ready = 2'b11;
      drv(0, 1'b1, OP_PLUS, 32'd7, 32'd8);
      drv(1, 1'b1, OP_PLUS, 32'd9, 32'd10);
`ifdef INTEGER_ALU_ARBITER_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = 1'b0;
`endif
      @(negedge clk);
      chk("post_idle_ready0", 64'(req_ready[0]), 64'(exp0));
      chk("post_idle_ready1", 64'(req_ready[1]), 64'(!exp0));
      sb_step();

      drv(0, 1'b0, OP_PLUS, 32'd0, 32'd0);
      drv(1, 1'b0, OP_PLUS, 32'd0, 32'd0);
      @(negedge clk);
      sb_step();
      @(negedge clk);
      sb_step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
